// File: rtl/temperature_pkg.sv
// Shared definitions for the sequential temperature monitor: width helpers and FSM states.
package temperature_pkg;

    // Ceiling log2 used to size counters and accumulators at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Bits needed to count 0..nr_sensors active channels.
    function automatic int cnt_width(input int nr_sensors);
        return clog2(nr_sensors + 1);
    endfunction

    // Bits needed to hold the sum of all readings without overflow.
    function automatic int sum_width(input int data_w, input int nr_sensors);
        return data_w + cnt_width(nr_sensors);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/division_seq.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// The first iteration is performed on the start edge straight from the
// operand inputs, so a DIVIDEND_W-bit division finishes DIVIDEND_W edges
// after (and including) the start edge; o_done is a one-cycle pulse.
// A zero divisor still runs the full sequence and the result reads as 0/0.
module division_seq
    import temperature_pkg::*;
#(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_done,
    output logic                  o_div_by_zero,
    output logic [DIVIDEND_W-1:0] o_quotient,
    output logic [DIVISOR_W:0]    o_remainder
);

    localparam int STEP_W = clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W:0]    r_rem;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_div;
    logic [STEP_W-1:0]     r_left;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_dbz;

    logic [DIVIDEND_W-1:0] w_src_quo;
    logic [DIVISOR_W-1:0]  w_src_div;
    logic [DIVISOR_W:0]    w_trial;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_fits;
    logic [DIVISOR_W:0]    w_rem_next;
    logic [DIVIDEND_W-1:0] w_quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_src_quo  = i_start ? i_dividend : r_quo;
        w_src_div  = i_start ? i_divisor  : r_div;
        w_trial    = {(i_start ? {DIVISOR_W{1'b0}} : r_rem[DIVISOR_W-1:0]),
                      w_src_quo[DIVIDEND_W-1]};
        w_diff     = w_trial - {1'b0, w_src_div};
        w_fits     = (w_trial >= {1'b0, w_src_div});
        w_rem_next = w_fits ? w_diff : w_trial;
        w_quo_next = {w_src_quo[DIVIDEND_W-2:0], w_fits};
    end

    // Iteration registers: load-and-step on start, then step until the count runs out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem  <= {(DIVISOR_W+1){1'b0}};
            r_quo  <= {DIVIDEND_W{1'b0}};
            r_div  <= {DIVISOR_W{1'b0}};
            r_left <= {STEP_W{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_div  <= i_divisor;
            r_dbz  <= (i_divisor == {DIVISOR_W{1'b0}});
            r_left <= STEP_W'(DIVIDEND_W - 1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_left <= r_left - STEP_W'(1);
            r_busy <= (r_left != STEP_W'(1));
            r_done <= (r_left == STEP_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_quotient    = r_dbz ? {DIVIDEND_W{1'b0}} : r_quo;
    assign o_remainder   = r_dbz ? {(DIVISOR_W+1){1'b0}} : r_rem;

endmodule

// File: rtl/temperature_monitor_seq.sv
// Sequential temperature monitor: snapshots all sensors on start, sums the
// enabled readings LANES per clock, divides by the active count and
// publishes a registered average, remainder, active count and range alert.
module temperature_monitor_seq
    import temperature_pkg::*;
#(
    parameter int NR_SENSORS = 200,
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int MIN_TEMP   = 19,
    parameter int MAX_TEMP   = 26,
    localparam int CNT_W     = cnt_width(NR_SENSORS),
    localparam int SUM_W     = sum_width(DATA_W, NR_SENSORS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [DATA_W*NR_SENSORS-1:0] sensors_data_i,
    input  logic [NR_SENSORS-1:0]        sensors_en_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [DATA_W-1:0]            led_output_o,
    output logic [SUM_W-1:0]             remainder_o,
    output logic [CNT_W-1:0]             nr_active_o,
    output logic                         alert_o
);

    // The snapshot is padded up to a whole number of lane groups; padding
    // lanes are disabled so they add nothing.
    localparam int NR_GROUPS = (NR_SENSORS + LANES - 1) / LANES;
    localparam int PAD_N     = NR_GROUPS * LANES;
    localparam int GRP_W     = clog2(NR_GROUPS + 1);
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NR_GROUPS - 1);

    state_e r_state;
    state_e w_state_next;

    logic [DATA_W*PAD_N-1:0] r_data;
    logic [PAD_N-1:0]        r_en;
    logic [SUM_W-1:0]        r_sum;
    logic [CNT_W-1:0]        r_cnt;
    logic [GRP_W-1:0]        r_grp;
    logic                    r_div_go;

    logic                    r_busy;
    logic                    r_done;
    logic [DATA_W-1:0]       r_led;
    logic [SUM_W-1:0]        r_rem;
    logic [CNT_W-1:0]        r_active;
    logic                    r_alert;

    logic                    w_capture;
    logic                    w_accum;
    logic                    w_launch;
    logic                    w_finish;
    logic [SUM_W-1:0]        w_grp_sum;
    logic [CNT_W-1:0]        w_grp_cnt;
    logic                    w_div_done;
    logic                    w_div_dbz;
    logic [SUM_W-1:0]        w_quo;
    logic [CNT_W:0]          w_div_rem;
    logic                    w_alert;

    division_seq #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_division_seq (
        .i_clk         (clk_i),
        .i_rst         (rst_i),
        .i_start       (r_div_go),
        .i_dividend    (r_sum),
        .i_divisor     (r_cnt),
        .o_done        (w_div_done),
        .o_div_by_zero (w_div_dbz),
        .o_quotient    (w_quo),
        .o_remainder   (w_div_rem)
    );

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accum      = 1'b0;
        w_launch     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_capture    = 1'b1;
                    w_state_next = ACCUM;
                end else begin
                    w_state_next = IDLE;
                end
            end
            ACCUM: begin
                w_accum = 1'b1;
                if (r_grp == LAST_GRP) begin
                    w_launch     = 1'b1;
                    w_state_next = DIVIDE;
                end else begin
                    w_state_next = ACCUM;
                end
            end
            DIVIDE: begin
                if (w_div_done) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_state_next = DIVIDE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sum and popcount of the lowest lane group of the shifting snapshot.
    always_comb begin
        w_grp_sum = {SUM_W{1'b0}};
        w_grp_cnt = {CNT_W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            w_grp_sum = w_grp_sum +
                        (r_en[l] ? SUM_W'(r_data[l*DATA_W +: DATA_W]) : {SUM_W{1'b0}});
            w_grp_cnt = w_grp_cnt + CNT_W'(r_en[l]);
        end
    end

    // Range check of the finished quotient; an empty snapshot always alerts.
    always_comb begin
        w_alert = w_div_dbz
                | (w_quo < SUM_W'(MIN_TEMP))
                | (w_quo > SUM_W'(MAX_TEMP));
    end

    // Snapshot capture, then shift one lane group per cycle into the accumulators.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data   <= {(DATA_W*PAD_N){1'b0}};
            r_en     <= {PAD_N{1'b0}};
            r_sum    <= {SUM_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_grp    <= {GRP_W{1'b0}};
            r_div_go <= 1'b0;
        end else begin
            r_div_go <= w_launch;
            if (w_capture) begin
                r_data <= (DATA_W*PAD_N)'(sensors_data_i);
                r_en   <= PAD_N'(sensors_en_i);
                r_sum  <= {SUM_W{1'b0}};
                r_cnt  <= {CNT_W{1'b0}};
                r_grp  <= {GRP_W{1'b0}};
            end else if (w_accum) begin
                r_data <= r_data >> (LANES*DATA_W);
                r_en   <= r_en >> LANES;
                r_sum  <= r_sum + w_grp_sum;
                r_cnt  <= r_cnt + w_grp_cnt;
                r_grp  <= r_grp + GRP_W'(1);
            end
        end
    end

    // Registered handshake and result outputs; results update only on completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_led    <= {DATA_W{1'b0}};
            r_rem    <= {SUM_W{1'b0}};
            r_active <= {CNT_W{1'b0}};
            r_alert  <= 1'b0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            r_done <= (w_state_next == DONE);
            if (w_finish) begin
                r_led    <= w_quo[DATA_W-1:0];
                r_rem    <= SUM_W'(w_div_rem);
                r_active <= r_cnt;
                r_alert  <= w_alert;
            end
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign led_output_o = r_led;
    assign remainder_o  = r_rem;
    assign nr_active_o  = r_active;
    assign alert_o      = r_alert;

endmodule
